// File: rtl/rgb_ram_writer.sv
// Writes the synchronised RGB pixel stream into a double-banked RAM region as RGB565,
// swapping banks on every complete frame and flagging malformed lines/frames.
module rgb_ram_writer #(
    parameter int LINE_PIXELS = 40,
    parameter int LINES       = 48,
    parameter int BANK_BASE_1 = 1920,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [23:0]       rgb,
    input  logic              rgb_valid,
    input  logic              hsync,
    input  logic              vsync,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [15:0]       ram_wdata,
    output logic              w_enable,
    output logic              read_bank,
    output logic              stream_ready,
    output logic              frame_error
);

    localparam int XW = $clog2(LINE_PIXELS + 1);
    localparam int YW = $clog2(LINES + 1);
    localparam logic [XW-1:0]     X_MAX  = XW'(LINE_PIXELS);
    localparam logic [YW-1:0]     Y_MAX  = YW'(LINES);
    localparam logic [YW-1:0]     Y_LAST = YW'(LINES - 1);
    localparam logic [ADDR_W-1:0] BASE1  = ADDR_W'(BANK_BASE_1);
    localparam logic [ADDR_W-1:0] LINE_A = ADDR_W'(LINE_PIXELS);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t            state, state_n;
    logic [XW-1:0]     x, x_n;
    logic [YW-1:0]     y, y_n;
    logic              wbank, wbank_n;
    logic              written, written_n;
    logic              rbank_n, ready_n, err_n, wen_n;
    logic [ADDR_W-1:0] waddr_n;
    logic [15:0]       wdata_n;
    logic              pix_ok, complete;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            wbank        <= 1'b1;
            written      <= 1'b0;
            read_bank    <= 1'b0;
            stream_ready <= 1'b0;
            frame_error  <= 1'b0;
            w_enable     <= 1'b0;
            ram_waddr    <= '0;
            ram_wdata    <= '0;
        end else begin
            state        <= state_n;
            x            <= x_n;
            y            <= y_n;
            wbank        <= wbank_n;
            written      <= written_n;
            read_bank    <= rbank_n;
            stream_ready <= ready_n;
            frame_error  <= err_n;
            w_enable     <= wen_n;
            ram_waddr    <= waddr_n;
            ram_wdata    <= wdata_n;
        end
    end

    assign pix_ok   = (x < X_MAX) && (y < Y_MAX);
    // A frame whose last line ends without a trailing hsync still counts as complete.
    assign complete = (y == Y_MAX) || ((y == Y_LAST) && (x == X_MAX));

    always_comb begin
        state_n   = state;
        x_n       = x;
        y_n       = y;
        wbank_n   = wbank;
        written_n = written;
        rbank_n   = read_bank;
        ready_n   = stream_ready;
        err_n     = frame_error;
        wen_n     = 1'b0;
        waddr_n   = ram_waddr;
        wdata_n   = ram_wdata;

        case (state)
            IDLE: begin
                if (vsync) begin
                    state_n   = ACTIVE;
                    x_n       = '0;
                    y_n       = '0;
                    written_n = 1'b0;
                end
            end
            ACTIVE: begin
                if (vsync) begin
                    if (complete) begin
                        rbank_n = wbank;
                        wbank_n = ~wbank;
                        ready_n = 1'b1;
                    end else if (written) begin
                        err_n = 1'b1;
                    end
                    x_n       = '0;
                    y_n       = '0;
                    written_n = 1'b0;
                end else if (hsync) begin
                    if (x != '0) begin
                        if (x < X_MAX) err_n = 1'b1;
                        if (y < Y_MAX) y_n = y + YW'(1);
                        x_n = '0;
                    end
                end else if (rgb_valid) begin
                    if (pix_ok) begin
                        wen_n     = 1'b1;
                        waddr_n   = (wbank ? BASE1 : '0) + ADDR_W'(y) * LINE_A + ADDR_W'(x);
                        wdata_n   = {rgb[23:19], rgb[15:10], rgb[7:3]};
                        x_n       = x + XW'(1);
                        written_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
